layer_scheduler: RTL



---
 rtl/gpu_layer_pkg.sv | 36 +++
 rtl/layer_line_hit.sv | 31 +++
 rtl/layer_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gpu_layer_pkg.sv
// Shared definitions for the layer pipeline: layer header layout, field locations
// and the scanline scheduler state encoding.
package gpu_layer_pkg;

  localparam int unsigned NUM_LAYERS = 32;
  localparam int unsigned LAYER_W    = 5;
  localparam int unsigned REG_W      = 16;

  localparam int unsigned ENABLE_BIT = 0;
  localparam int unsigned YSTART_REG = 1;
  localparam int unsigned YEND_REG   = 2;

  // reg0 occupies the low 16 bits of the flat header
  typedef struct packed {
    logic [REG_W-1:0] reg3;
    logic [REG_W-1:0] reg2;
    logic [REG_W-1:0] reg1;
    logic [REG_W-1:0] reg0;
  } layer_header_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StEval,
    StOffer,
    StFinish
  } sched_state_e;

  function automatic logic [REG_W-1:0] header_reg(input layer_header_t hdr,
                                                  input int unsigned  idx);
    logic [4*REG_W-1:0] flat;
    flat = hdr;
    return flat[idx*REG_W +: REG_W];
  endfunction

endpackage

// File: rtl/layer_line_hit.sv
// Decides whether a layer header covers a given scanline; shared with the sprite path.
module layer_line_hit
  import gpu_layer_pkg::*;
#(
  parameter int unsigned Y_W = 10
) (
  input  layer_header_t  header,
  input  logic [Y_W-1:0] line_y,
  output logic           active
);

  logic [REG_W-1:0] reg0;
  logic [REG_W-1:0] ystart_reg;
  logic [REG_W-1:0] yend_reg;
  logic [Y_W-1:0]   y_start;
  logic [Y_W-1:0]   y_end;
  logic             unused_header;

  always_comb begin
    reg0       = header_reg(header, 0);
    ystart_reg = header_reg(header, YSTART_REG);
    yend_reg   = header_reg(header, YEND_REG);
    y_start    = ystart_reg[Y_W-1:0];
    y_end      = yend_reg[Y_W-1:0];
    // An inverted window (y_start > y_end) never matches; no wrap-around.
    active     = reg0[ENABLE_BIT] && (y_start <= line_y) && (line_y <= y_end);
  end

  assign unused_header = ^header;

endmodule

// File: rtl/layer_scheduler.sv
// Per-scanline walker over the layer register file: fetches each header in order and
// offers every layer active on the current line to the renderer over valid/ready.
module layer_scheduler
  import gpu_layer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = gpu_layer_pkg::NUM_LAYERS,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           line_start,
  input  logic [Y_W-1:0] line_y,
  output logic [4:0]     pipe_layer,
  input  logic [63:0]    pipe_allRegisters,
  output logic           layer_valid,
  input  logic           layer_ready,
  output logic [4:0]     layer_id,
  output logic [63:0]    layer_header,
  output logic           line_done,
  output logic           line_abort,
  output logic           busy,
  output logic           overrun,
  input  logic           overrun_clr
);

  localparam logic [1:0] LoadCnt = 2'(READ_LAT);
  localparam logic [4:0] LastIdx = 5'(NUM_LAYERS - 1);

  sched_state_e   state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [Y_W-1:0] line_y_q, line_y_d;
  logic [4:0]     id_q, id_d;
  logic [63:0]    hdr_q, hdr_d;
  logic           abort_q, abort_d;
  logic           overrun_q, overrun_d;
  logic           hit;
  logic           advance;

  layer_line_hit #(
    .Y_W (Y_W)
  ) u_line_hit (
    .header (layer_header_t'(pipe_allRegisters)),
    .line_y (line_y_q),
    .active (hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    line_y_d  = line_y_q;
    id_d      = id_q;
    hdr_d     = hdr_q;
    abort_d   = 1'b0;
    overrun_d = overrun_q;
    advance   = 1'b0;

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    if (line_start) begin
      // A new line always restarts the walk, killing any scan in flight.
      line_y_d = line_y;
      idx_d    = '0;
      cnt_d    = LoadCnt;
      state_d  = StFetch;
      if (state_q != StIdle) begin
        abort_d   = 1'b1;
        overrun_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StFetch: begin
          if (cnt_q == '0) begin
            state_d = StEval;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        StEval: begin
          if (hit) begin
            id_d    = idx_q;
            hdr_d   = pipe_allRegisters;
            state_d = StOffer;
          end else begin
            advance = 1'b1;
          end
        end
        StOffer:  advance = layer_ready;
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase

      if (advance) begin
        if (idx_q == LastIdx) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q + 5'd1;
          cnt_d   = LoadCnt;
          state_d = StFetch;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      line_y_q  <= '0;
      id_q      <= '0;
      hdr_q     <= '0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      line_y_q  <= line_y_d;
      id_q      <= id_d;
      hdr_q     <= hdr_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
    end
  end

  assign pipe_layer   = idx_q;
  assign layer_valid  = (state_q == StOffer);
  assign layer_id     = id_q;
  assign layer_header = hdr_q;
  // A restart landing on FINISH suppresses the completion of the aborted line.
  assign line_done    = (state_q == StFinish) && !line_start;
  assign line_abort   = abort_q;
  assign busy         = (state_q != StIdle);
  assign overrun      = overrun_q;

endmodule
